// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter timer with load, auto-reload, pause,
// sticky fault and one-cycle terminal-count pulse.
module bcd_down_timer #(
    parameter int unsigned           DIGITS = 2,
    parameter logic [4*DIGITS-1:0]   PRESET = 8'h30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pause,
    input  logic                  error,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  auto_reload,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  zero,
    output logic                  done,
    output logic                  running,
    output logic                  fault
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE,
        S_FAULT
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   count, count_nxt;
    logic [W-1:0]   reload, reload_nxt;
    logic           done_nxt;
    logic [W-1:0]   load_clamped;
    logic           go;

    // Saturate every decade above 9 down to 9.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Subtract one in BCD; a zero decade wraps to 9 and borrows upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign load_clamped = bcd_clamp(load_value);
    assign go           = enable & ~pause;
    assign bcd          = count;

    // State, count and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= PRESET;
            reload  <= PRESET;
            done    <= 1'b0;
            zero    <= (PRESET == '0);
            running <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            reload  <= reload_nxt;
            done    <= done_nxt;
            zero    <= (count_nxt == '0);
            running <= (state_nxt == S_RUN);
            fault   <= (state_nxt == S_FAULT);
        end
    end

    // Next-state and next-count: error > load > pause > enable/count.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        done_nxt   = 1'b0;

        if (error) begin
            state_nxt = S_FAULT;
            count_nxt = '0;
        end else if (load) begin
            count_nxt  = load_clamped;
            reload_nxt = load_clamped;
            state_nxt  = (load_clamped == '0) ? S_DONE : S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    // A zero count can never run; park it as expired.
                    if (go) begin
                        state_nxt = (count == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (count == '0) begin
                        // Auto-reload: zero is shown for exactly one cycle.
                        count_nxt = reload;
                        if (pause) begin
                            state_nxt = S_PAUSED;
                        end
                    end else if (pause) begin
                        state_nxt = S_PAUSED;
                    end else if (enable) begin
                        count_nxt = bcd_dec(count);
                        if (count == W'(1)) begin
                            done_nxt = 1'b1;
                            if (!auto_reload) begin
                                state_nxt = S_DONE;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (go) begin
                        state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                end
                S_FAULT: begin
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed table, hand-written
// corner sequences and a randomized run against a decimal reference model.
module tb_bcd_down_timer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        pause;
    logic        error;
    logic        load;
    logic [7:0]  load_value;
    logic        auto_reload;
    logic [7:0]  bcd;
    logic        zero, done, running, fault;

    logic        load3;
    logic [11:0] load_value3;
    logic [11:0] bcd3;
    logic        zero3, done3, running3, fault3;

    int checks;
    int errors;

    bcd_down_timer #(.DIGITS(2), .PRESET(8'h30)) dut (
        .clock(clock), .reset(reset), .enable(enable), .pause(pause),
        .error(error), .load(load), .load_value(load_value),
        .auto_reload(auto_reload), .bcd(bcd), .zero(zero), .done(done),
        .running(running), .fault(fault)
    );

    bcd_down_timer #(.DIGITS(3), .PRESET(12'h250)) dut3 (
        .clock(clock), .reset(reset), .enable(enable), .pause(pause),
        .error(error), .load(load3), .load_value(load_value3),
        .auto_reload(auto_reload), .bcd(bcd3), .zero(zero3), .done(done3),
        .running(running3), .fault(fault3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst, en, pa, er, ld, ar;
        logic [7:0] lv;
        logic [7:0] e_bcd;
        logic       e_zero, e_done, e_run, e_fault;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic rst, en, pa, er, ld, ar,
                                input logic [7:0] lv, input logic [7:0] eb,
                                input logic ez, ed, erun, ef);
        vec_t v;
        v.rst = rst; v.en = en; v.pa = pa; v.er = er; v.ld = ld; v.ar = ar;
        v.lv = lv; v.e_bcd = eb; v.e_zero = ez; v.e_done = ed;
        v.e_run = erun; v.e_fault = ef;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [11:0] to_bcd3(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_int(input logic [7:0] v);
        int hi, lo;
        hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        reset = 1'b0; enable = 1'b0; pause = 1'b0; error = 1'b0;
        load = 1'b0; load_value = 8'h00; load3 = 1'b0; load_value3 = 12'h000;
    endtask

    // Reference model: integer count and a mode code.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3, M_FAULT = 4;
    int m_cnt, m_rel, m_mode;
    bit m_done;

    task automatic m_step;
        int v;
        if (reset) begin
            m_cnt = 30; m_rel = 30; m_mode = M_IDLE; m_done = 0;
        end else begin
            m_done = 0;
            if (error) begin
                m_mode = M_FAULT; m_cnt = 0;
            end else if (load) begin
                v = clamp_int(load_value);
                m_cnt = v; m_rel = v;
                m_mode = (v == 0) ? M_DONE : M_IDLE;
            end else if (m_mode == M_IDLE) begin
                if (enable && !pause) m_mode = (m_cnt == 0) ? M_DONE : M_RUN;
            end else if (m_mode == M_RUN) begin
                if (m_cnt == 0) begin
                    m_cnt = m_rel;
                    if (pause) m_mode = M_PAUSED;
                end else if (pause) begin
                    m_mode = M_PAUSED;
                end else if (enable) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_done = 1;
                        if (!auto_reload) m_mode = M_DONE;
                    end
                end
            end else if (m_mode == M_PAUSED) begin
                if (enable && !pause) m_mode = M_RUN;
            end
        end
    endtask

    initial begin
        int exp_v;
        int pulses;
        logic [7:0] eb;
        logic       nib_ok;

        checks = 0;
        errors = 0;
        idle_inputs();
        auto_reload = 1'b0;

        // Directed vector table.
        vecs[0]  = mk(1,0,0,0,0,0, 8'h00, 8'h30, 0,0,0,0);
        vecs[1]  = mk(0,0,0,0,1,0, 8'hA7, 8'h97, 0,0,0,0);
        vecs[2]  = mk(0,1,0,0,0,0, 8'h00, 8'h97, 0,0,1,0);
        vecs[3]  = mk(0,1,0,0,0,0, 8'h00, 8'h96, 0,0,1,0);
        vecs[4]  = mk(0,0,0,0,0,0, 8'h00, 8'h96, 0,0,1,0);
        vecs[5]  = mk(0,1,1,0,0,0, 8'h00, 8'h96, 0,0,0,0);
        vecs[6]  = mk(0,0,1,0,1,0, 8'h12, 8'h12, 0,0,0,0);
        vecs[7]  = mk(0,1,0,0,0,0, 8'h00, 8'h12, 0,0,1,0);
        vecs[8]  = mk(0,1,0,0,0,0, 8'h00, 8'h11, 0,0,1,0);
        vecs[9]  = mk(0,1,0,1,0,0, 8'h00, 8'h00, 1,0,0,1);
        vecs[10] = mk(0,1,0,0,0,0, 8'h00, 8'h00, 1,0,0,1);
        vecs[11] = mk(0,0,0,1,1,0, 8'h42, 8'h00, 1,0,0,1);
        vecs[12] = mk(0,0,0,0,1,0, 8'h00, 8'h00, 1,0,0,0);
        vecs[13] = mk(0,1,0,0,0,0, 8'h00, 8'h00, 1,0,0,0);
        vecs[14] = mk(0,0,0,0,1,0, 8'h02, 8'h02, 0,0,0,0);
        vecs[15] = mk(0,1,0,0,0,0, 8'h00, 8'h02, 0,0,1,0);
        vecs[16] = mk(0,1,0,0,0,0, 8'h00, 8'h01, 0,0,1,0);
        vecs[17] = mk(0,1,0,0,0,0, 8'h00, 8'h00, 1,1,0,0);
        vecs[18] = mk(0,1,0,0,0,0, 8'h00, 8'h00, 1,0,0,0);
        vecs[19] = mk(0,0,0,0,1,0, 8'hF0, 8'h90, 0,0,0,0);
        vecs[20] = mk(1,1,0,0,0,0, 8'h00, 8'h30, 0,0,0,0);

        for (int i = 0; i < 21; i++) begin
            reset = vecs[i].rst; enable = vecs[i].en; pause = vecs[i].pa;
            error = vecs[i].er; load = vecs[i].ld; auto_reload = vecs[i].ar;
            load_value = vecs[i].lv;
            tick();
            chk($sformatf("vec%0d", i), 32'({bcd, zero, done, running, fault}),
                32'({vecs[i].e_bcd, vecs[i].e_zero, vecs[i].e_done,
                     vecs[i].e_run, vecs[i].e_fault}));
        end

        // Full countdown from reset preset.
        idle_inputs();
        reset = 1'b1;
        tick();
        chk("reset_state", 32'({bcd, zero, done, running, fault}), 32'({8'h30, 4'b0000}));
        reset = 1'b0;
        enable = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 42; k++) begin
            tick();
            exp_v = (k == 1) ? 30 : ((k <= 31) ? 31 - k : 0);
            eb = to_bcd2(exp_v);
            if (done) pulses++;
            chk($sformatf("countdown_k%0d", k), 32'({bcd, zero, done, running, fault}),
                32'({eb, exp_v == 0, k == 31, k <= 30, 1'b0}));
        end
        chk("countdown_pulses", 32'(pulses), 32'd1);

        // Borrow chain on the three-digit instance.
        idle_inputs();
        load3 = 1'b1; load_value3 = 12'h100;
        tick();
        chk("b3_load", 32'({bcd3, running3}), 32'({12'h100, 1'b0}));
        load3 = 1'b0; enable = 1'b1;
        tick();
        chk("b3_run", 32'({bcd3, running3}), 32'({12'h100, 1'b1}));
        for (int v = 99; v >= 0; v--) begin
            tick();
            nib_ok = (bcd3[3:0] <= 4'd9) && (bcd3[7:4] <= 4'd9) && (bcd3[11:8] <= 4'd9);
            chk($sformatf("b3_val%0d", v), 32'({bcd3, done3}), 32'({to_bcd3(v), v == 0}));
            chk($sformatf("b3_nib%0d", v), 32'(nib_ok), 32'd1);
        end

        // Pause mid-run at 17.
        idle_inputs();
        load = 1'b1; load_value = 8'h20; enable = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        chk("pause_pre", 32'({bcd, running}), 32'({8'h17, 1'b1}));
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("pause_hold%0d", k), 32'({bcd, running}), 32'({8'h17, 1'b0}));
        end
        pause = 1'b0;
        tick();
        chk("pause_rel1", 32'({bcd, running}), 32'({8'h17, 1'b1}));
        tick();
        chk("pause_rel2", 32'({bcd, running}), 32'({8'h16, 1'b1}));

        // Auto-reload loop from 03.
        idle_inputs();
        auto_reload = 1'b1;
        load = 1'b1; load_value = 8'h03; enable = 1'b1;
        tick();
        chk("ar_load", 32'({bcd, running}), 32'({8'h03, 1'b0}));
        load = 1'b0;
        tick();
        chk("ar_run", 32'({bcd, done, running}), 32'({8'h03, 1'b0, 1'b1}));
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_v = ((i % 4) == 3) ? 3 : 2 - (i % 4);
            chk($sformatf("ar_seq%0d", i), 32'({bcd, done, running}),
                32'({to_bcd2(exp_v), exp_v == 0, 1'b1}));
        end
        auto_reload = 1'b0;

        // Fault while counting, then recovery by load.
        idle_inputs();
        load = 1'b1; load_value = 8'h14;
        tick();
        load = 1'b0; enable = 1'b1;
        repeat (3) tick();
        chk("flt_pre", 32'(bcd), 32'(8'h12));
        error = 1'b1;
        tick();
        chk("flt_enter", 32'({bcd, fault, running}), 32'({8'h00, 1'b1, 1'b0}));
        error = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("flt_hold%0d", k), 32'({bcd, fault, running}), 32'({8'h00, 1'b1, 1'b0}));
        end
        enable = 1'b0; load = 1'b1; load_value = 8'h05;
        tick();
        chk("flt_exit", 32'({bcd, zero, done, running, fault}), 32'({8'h05, 4'b0000}));

        // Randomized run against the reference model.
        idle_inputs();
        reset = 1'b1;
        m_step();
        tick();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            error = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 24) == 0);
            load_value = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            pause = ($urandom_range(0, 9) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) auto_reload = ~auto_reload;
            m_step();
            tick();
            chk($sformatf("rand%0d", c), 32'({bcd, zero, done, running, fault}),
                32'({to_bcd2(m_cnt), m_cnt == 0, m_done, m_mode == M_RUN, m_mode == M_FAULT}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
